// File: rtl/cpu_multicycle.sv
// Multicycle RV-style core with a register file, ALU, immediate generator and
// data memory. An internal FSM sequences each accepted instruction through
// DECODE, EXEC and the optional MEM and WB states, and then returns to IDLE.
module cpu_multicycle #(
  parameter int WORDSIZE  = 64,
  parameter int REG_COUNT = 32,
  parameter int DM_DEPTH  = 64,
  parameter int COUNT_W   = 16,
  localparam int DM_AW    = $clog2(DM_DEPTH)
) (
  input  logic                cpu_clk,
  input  logic                cpu_rst,
  input  logic [31:0]         cpu_instr,
  input  logic                cpu_instr_valid,
  output logic                cpu_instr_ready,
  output logic                cpu_busy,
  output logic                cpu_done,
  output logic                cpu_illegal,
  output logic [COUNT_W-1:0]  cpu_retired_count,
  input  logic [4:0]          cpu_dbg_rf_addr,
  output logic [WORDSIZE-1:0] cpu_reading_rf_data,
  input  logic [DM_AW-1:0]    cpu_dbg_dm_addr,
  output logic [WORDSIZE-1:0] cpu_reading_dm_data
);

  localparam int         RF_AW     = $clog2(REG_COUNT);
  localparam logic [5:0] REG_LIMIT = 6'(REG_COUNT);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLT} alu_op_t;

  state_t state_q, state_d;

  logic [31:0]         instr_q;
  logic [WORDSIZE-1:0] a_q, b_q, imm_q, alu_q, mdr_q;
  logic [WORDSIZE-1:0] alu_d, op_b, wb_d;
  logic [COUNT_W-1:0]  retired_q;

  logic [WORDSIZE-1:0] rf_q [REG_COUNT];
  logic [WORDSIZE-1:0] dm_q [DM_DEPTH];

  // Instruction fields, always taken from the latched word
  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign f3     = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign f7     = instr_q[31:25];

  logic    is_load, is_store, is_rtype, op_ok, uses_rs2, writes_rd, legal;
  alu_op_t alu_op;
  logic    accept, rf_we, dm_we;

  // Decode: classify the latched instruction and pick the ALU operation
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_rtype  = 1'b0;
    op_ok     = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    alu_op    = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        is_rtype  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
        if (f7 == 7'b0000000) begin
          op_ok = 1'b1;
          case (f3)
            3'b000:  alu_op = ALU_ADD;
            3'b010:  alu_op = ALU_SLT;
            3'b100:  alu_op = ALU_XOR;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: op_ok = 1'b0;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          op_ok  = 1'b1;
          alu_op = ALU_SUB;
        end
      end
      OPC_OP_IMM: begin
        writes_rd = 1'b1;
        op_ok     = 1'b1;
        case (f3)
          3'b000:  alu_op = ALU_ADD;
          3'b100:  alu_op = ALU_XOR;
          3'b110:  alu_op = ALU_OR;
          3'b111:  alu_op = ALU_AND;
          default: op_ok = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        is_load   = 1'b1;
        writes_rd = 1'b1;
        op_ok     = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_STORE: begin
        is_store = 1'b1;
        uses_rs2 = 1'b1;
        op_ok    = (f3 == 3'b010) || (f3 == 3'b011);
      end
      default: op_ok = 1'b0;
    endcase
    // Only the register fields the format actually uses must be in range
    legal = op_ok
          && ({1'b0, rs1} < REG_LIMIT)
          && (!uses_rs2  || ({1'b0, rs2} < REG_LIMIT))
          && (!writes_rd || ({1'b0, rd}  < REG_LIMIT));
  end

  // ALU: R-type uses rs2, every other format uses the immediate; wraps modulo 2^WORDSIZE
  always_comb begin
    op_b  = is_rtype ? b_q : imm_q;
    alu_d = a_q + op_b;
    case (alu_op)
      ALU_SUB: alu_d = a_q - op_b;
      ALU_XOR: alu_d = a_q ^ op_b;
      ALU_OR:  alu_d = a_q | op_b;
      ALU_AND: alu_d = a_q & op_b;
      ALU_SLT: alu_d = {{(WORDSIZE-1){1'b0}}, ($signed(a_q) < $signed(op_b))};
      default: alu_d = a_q + op_b;
    endcase
  end

  assign wb_d = is_load ? mdr_q : alu_q;

  // FSM state register
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_DECODE;
      S_DECODE: state_d = legal ? S_EXEC : S_IDLE;
      S_EXEC:   state_d = (is_load || is_store) ? S_MEM : S_WB;
      S_MEM:    state_d = is_store ? S_IDLE : S_WB;
      S_WB:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: handshake, status pulses and write enables
  always_comb begin
    cpu_instr_ready = 1'b0;
    cpu_busy        = 1'b1;
    cpu_done        = 1'b0;
    cpu_illegal     = 1'b0;
    rf_we           = 1'b0;
    dm_we           = 1'b0;
    case (state_q)
      S_IDLE: begin
        cpu_instr_ready = ~cpu_rst;
        cpu_busy        = 1'b0;
      end
      S_DECODE: cpu_illegal = ~legal;
      S_MEM: begin
        cpu_done = is_store;
        dm_we    = is_store;
      end
      S_WB: begin
        cpu_done = 1'b1;
        rf_we    = (rd != 5'd0);
      end
      default: ;
    endcase
  end

  assign accept = cpu_instr_valid & cpu_instr_ready;

  // Datapath registers: instruction latch, operands, ALU result, load data
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
    end else begin
      if (accept) instr_q <= cpu_instr;
      if (state_q == S_DECODE) begin
        a_q   <= rf_q[rs1[RF_AW-1:0]];
        b_q   <= rf_q[rs2[RF_AW-1:0]];
        imm_q <= is_store ? {{(WORDSIZE-12){instr_q[31]}}, instr_q[31:25], instr_q[11:7]}
                          : {{(WORDSIZE-12){instr_q[31]}}, instr_q[31:20]};
      end
      if (state_q == S_EXEC) alu_q <= alu_d;
      if (state_q == S_MEM)  mdr_q <= dm_q[alu_q[DM_AW-1:0]];
    end
  end

  // Register file; entry 0 is never written so x0 stays zero
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rd[RF_AW-1:0]] <= wb_d;
    end
  end

  // Data memory, word-addressed by the low address bits of rs1 + imm
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      for (int i = 0; i < DM_DEPTH; i++) dm_q[i] <= '0;
    end else if (dm_we) begin
      dm_q[alu_q[DM_AW-1:0]] <= b_q;
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst)       retired_q <= '0;
    else if (cpu_done) retired_q <= retired_q + 1'b1;
  end

  assign cpu_retired_count   = retired_q;
  assign cpu_reading_rf_data = ({1'b0, cpu_dbg_rf_addr} < REG_LIMIT)
                             ? rf_q[cpu_dbg_rf_addr[RF_AW-1:0]] : '0;
  assign cpu_reading_dm_data = dm_q[cpu_dbg_dm_addr];

endmodule
